// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into click / long / repeat / long-release events
// and presents them through a one-deep valid/ready output register.
module button_event_decoder #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned LONG_TICKS   = 500,
  parameter int unsigned REPEAT_TICKS = 100,
  parameter bit          REPEAT_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       debounced,
  input  logic       tick,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ready,
  output logic       held,
  output logic       overflow,
  input  logic       ovf_clr
);

  typedef enum logic [1:0] {
    StIdle,
    StPressed,
    StLongHeld
  } state_e;

  typedef enum logic [1:0] {
    EvtClick       = 2'b00,
    EvtLong        = 2'b01,
    EvtRepeat      = 2'b10,
    EvtLongRelease = 2'b11
  } evt_e;

  localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_TICKS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             held_q;
  logic             evt_valid_q, evt_valid_d;
  logic [1:0]       evt_code_q, evt_code_d;
  logic             overflow_q, overflow_d;

  logic             emit;
  evt_e             emit_code;
  logic             drop;

  // Press classification; release always wins over a threshold tick in the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    emit      = 1'b0;
    emit_code = EvtClick;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (debounced) begin
          state_d = StPressed;
        end
      end
      StPressed: begin
        if (!debounced) begin
          emit      = 1'b1;
          emit_code = EvtClick;
          state_d   = StIdle;
          cnt_d     = '0;
        end else if (tick && (cnt_q == LongLast)) begin
          emit      = 1'b1;
          emit_code = EvtLong;
          state_d   = StLongHeld;
          cnt_d     = '0;
        end else if (tick) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StLongHeld: begin
        if (!debounced) begin
          emit      = 1'b1;
          emit_code = EvtLongRelease;
          state_d   = StIdle;
          cnt_d     = '0;
        end else if (REPEAT_EN && tick && (cnt_q == RepeatLast)) begin
          emit      = 1'b1;
          emit_code = EvtRepeat;
          cnt_d     = '0;
        end else if (tick && (cnt_q != RepeatLast)) begin
          // With repeats disabled the count parks at the last value instead of wrapping.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // One-deep output register: accept-and-load in one cycle, otherwise a new event is dropped.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    overflow_d  = overflow_q;
    drop        = 1'b0;
    if (emit && (!evt_valid_q || evt_ready)) begin
      evt_valid_d = 1'b1;
      evt_code_d  = emit_code;
    end else if (emit) begin
      drop = 1'b1;
    end else if (evt_ready) begin
      evt_valid_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      held_q      <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= 2'b00;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      held_q      <= (state_d != StIdle);
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      overflow_q  <= overflow_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign held      = held_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder: one instance with repeats, one without,
// driven by the same stimulus and checked against a behavioural model.
module tb_button_event_decoder;

  localparam int unsigned LT = 4;
  localparam int unsigned RT = 2;

  logic clk;
  logic reset_n;
  logic debounced;
  logic tick;
  logic evt_ready;
  logic ovf_clr;

  logic       v_w [2];
  logic [1:0] c_w [2];
  logic       h_w [2];
  logic       o_w [2];

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state per instance (0: repeats on, 1: repeats off).
  int         m_state [2];
  int         m_cnt   [2];
  bit         m_valid [2];
  bit         m_ovf   [2];
  logic [1:0] sbq0 [$];
  logic [1:0] sbq1 [$];
  logic [1:0] log0 [$];
  logic [1:0] log1 [$];

  button_event_decoder #(
    .CNT_W       (16),
    .LONG_TICKS  (LT),
    .REPEAT_TICKS(RT),
    .REPEAT_EN   (1'b1)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .debounced(debounced),
    .tick     (tick),
    .evt_valid(v_w[0]),
    .evt_code (c_w[0]),
    .evt_ready(evt_ready),
    .held     (h_w[0]),
    .overflow (o_w[0]),
    .ovf_clr  (ovf_clr)
  );

  button_event_decoder #(
    .CNT_W       (16),
    .LONG_TICKS  (LT),
    .REPEAT_TICKS(RT),
    .REPEAT_EN   (1'b0)
  ) dut_norep (
    .clk      (clk),
    .reset_n  (reset_n),
    .debounced(debounced),
    .tick     (tick),
    .evt_valid(v_w[1]),
    .evt_code (c_w[1]),
    .evt_ready(evt_ready),
    .held     (h_w[1]),
    .overflow (o_w[1]),
    .ovf_clr  (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic sb_push(input int i, input logic [1:0] code);
    if (i == 0) sbq0.push_back(code);
    else        sbq1.push_back(code);
  endtask

  task automatic model_step(input int i, input logic deb, input logic tk, input logic rdy,
                            input logic clr, input logic rstn);
    bit         emit;
    bit         drop;
    bit         re;
    logic [1:0] ec;
    emit = 1'b0;
    drop = 1'b0;
    ec   = 2'b00;
    re   = (i == 0);
    if (!rstn) begin
      m_state[i] = 0;
      m_cnt[i]   = 0;
      m_valid[i] = 1'b0;
      m_ovf[i]   = 1'b0;
      if (i == 0) sbq0.delete();
      else        sbq1.delete();
      return;
    end
    case (m_state[i])
      0: begin
        m_cnt[i] = 0;
        if (deb) m_state[i] = 1;
      end
      1: begin
        if (!deb) begin
          emit = 1'b1; ec = 2'b00; m_state[i] = 0; m_cnt[i] = 0;
        end else if (tk) begin
          if (m_cnt[i] == int'(LT) - 1) begin
            emit = 1'b1; ec = 2'b01; m_state[i] = 2; m_cnt[i] = 0;
          end else begin
            m_cnt[i]++;
          end
        end
      end
      default: begin
        if (!deb) begin
          emit = 1'b1; ec = 2'b11; m_state[i] = 0; m_cnt[i] = 0;
        end else if (tk) begin
          if (re && m_cnt[i] == int'(RT) - 1) begin
            emit = 1'b1; ec = 2'b10; m_cnt[i] = 0;
          end else if (m_cnt[i] < int'(RT) - 1) begin
            m_cnt[i]++;
          end
        end
      end
    endcase
    if (emit && (!m_valid[i] || rdy)) begin
      m_valid[i] = 1'b1;
      sb_push(i, ec);
    end else if (emit) begin
      drop     = 1'b1;
      m_ovf[i] = 1'b1;
    end else if (rdy) begin
      m_valid[i] = 1'b0;
    end
    if (clr && !drop) m_ovf[i] = 1'b0;
  endtask

  // One clock: drive inputs, retire any handshake, advance model, then compare after the edge.
  task automatic cycle(input logic deb, input logic tk, input logic rdy, input logic clr,
                       input logic rstn);
    logic [1:0] exp_code;
    debounced = deb;
    tick      = tk;
    evt_ready = rdy;
    ovf_clr   = clr;
    reset_n   = rstn;
    for (int i = 0; i < 2; i++) begin
      if (rstn && v_w[i] === 1'b1 && rdy) begin
        if ((i == 0 ? sbq0.size() : sbq1.size()) == 0) begin
          check_eq($sformatf("sb_nonempty[%0d]", i), 32'd0, 32'd1);
        end else begin
          exp_code = (i == 0) ? sbq0.pop_front() : sbq1.pop_front();
          check_eq($sformatf("accept_code[%0d]", i), 32'(c_w[i]), 32'(exp_code));
        end
        if (i == 0) log0.push_back(c_w[i]);
        else        log1.push_back(c_w[i]);
      end
      model_step(i, deb, tk, rdy, clr, rstn);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("evt_valid[%0d]", i), 32'(v_w[i]), 32'(m_valid[i]));
      check_eq($sformatf("held[%0d]", i), 32'(h_w[i]), 32'(m_state[i] != 0));
      check_eq($sformatf("overflow[%0d]", i), 32'(o_w[i]), 32'(m_ovf[i]));
      if (m_valid[i]) begin
        exp_code = (i == 0) ? sbq0[0] : sbq1[0];
        check_eq($sformatf("evt_code[%0d]", i), 32'(c_w[i]), 32'(exp_code));
      end
    end
  endtask

  // Compare the accepted-event log against a literal list (element k at codes[2k+1:2k]).
  task automatic check_log(input int i, input string name, input int n, input logic [9:0] codes);
    logic [1:0] got_q [$];
    if (i == 0) got_q = log0;
    else        got_q = log1;
    check_eq($sformatf("%s_count[%0d]", name, i), 32'(got_q.size()), 32'(n));
    for (int k = 0; k < n; k++) begin
      if (k < got_q.size()) begin
        check_eq($sformatf("%s_evt%0d[%0d]", name, k, i), 32'(got_q[k]), 32'(codes[2*k +: 2]));
      end
    end
    if (i == 0) log0.delete();
    else        log1.delete();
  endtask

  task automatic drain();
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    reset_n   = 1'b0;
    debounced = 1'b0;
    tick      = 1'b0;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;

    // Reset held with button pressed and ticks running.
    repeat (3) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("rst_valid", 32'(v_w[0]), 32'd0);
    check_eq("rst_held", 32'(h_w[0]), 32'd0);
    check_eq("rst_ovf", 32'(o_w[0]), 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("held_after_rst", 32'(h_w[0]), 32'd1);
    drain();
    check_log(0, "rst", 1, 10'b00);
    check_log(1, "rst", 1, 10'b00);

    // Short click.
    repeat (3) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("click_held", 32'(h_w[0]), 32'd0);
    check_log(0, "click", 1, 10'b00);
    check_log(1, "click", 1, 10'b00);

    // Long press with repeats, then release.
    repeat (12) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check_log(0, "long", 5, 10'b11_10_10_10_01);
    check_log(1, "long", 2, 10'b11_01);

    // Release on the same cycle as the LONG threshold tick.
    repeat (4) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    drain();
    check_log(0, "tie", 1, 10'b00);
    check_log(1, "tie", 1, 10'b00);

    // Backpressure: LONG stalls, two REPEATs are dropped.
    repeat (9) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("bp_code", 32'(c_w[0]), 32'd1);
    check_eq("bp_ovf", 32'(o_w[0]), 32'd1);
    check_eq("bp_ovf_norep", 32'(o_w[1]), 32'd0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("bp_accepted", 32'(v_w[0]), 32'd0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("bp_ovf_clr", 32'(o_w[0]), 32'd0);
    drain();
    check_log(0, "bp", 2, 10'b11_01);
    check_log(1, "bp", 2, 10'b11_01);

    // Ticks gated off: no LONG; then reset aborts the press.
    repeat (50) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("gate_held", 32'(h_w[0]), 32'd1);
    check_eq("gate_valid", 32'(v_w[0]), 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    check_eq("abort_held", 32'(h_w[0]), 32'd0);
    check_log(0, "abort", 0, 10'b0);
    check_log(1, "abort", 0, 10'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
